// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types, sizes and helpers for the MEM-stage data cache
package mips_mem_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;
    localparam int LINE_BYTES = 4;
    // byte lanes are big-endian: offset 0 is bits 31:24, enable bit 3
    function automatic logic [LINE_BYTES-1:0] sb_be(input logic [1:0] off);
        return 4'b1000 >> off;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/mem_stage_cache_if.sv
// mem_stage_cache_if: main-memory request/ready port of the MEM-stage cache
interface mem_stage_cache_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_stage_cache_array.sv
// cache_array: direct-mapped valid/tag/data store, async read, byte-enabled sync write
module cache_array
    import mips_mem_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [INDEX_BITS-1:0]   rd_index,
    output logic                    rd_valid,
    output logic [29-INDEX_BITS:0]  rd_tag,
    output logic [31:0]             rd_data,
    input  logic                    we,
    input  logic [INDEX_BITS-1:0]   wr_index,
    input  logic [29-INDEX_BITS:0]  wr_tag,
    input  logic [LINE_BYTES-1:0]   wr_be,
    input  logic [31:0]             wr_data
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0]          valid_q, valid_d;
    logic [29-INDEX_BITS:0]    tag_q [LINES];
    logic [31:0]               data_q [LINES];
    logic [31:0]               data_d;
    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];
    always_comb begin
        valid_d = valid_q | (we ? (LINES'(1) << wr_index) : '0);
        data_d  = data_q[wr_index];
        for (int b = 0; b < LINE_BYTES; b++)
            if (wr_be[b]) data_d[8*b +: 8] = wr_data[8*b +: 8];
    end
    always_ff @(posedge clk) begin
        if (!rst_b) valid_q <= '0;
        else valid_q <= valid_d;
    end
    // tag/data need no reset: a line is only read once its valid bit is set
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= data_d;
        end
    end
endmodule

// File: rtl/mem_stage_cache.sv
// mem_stage_cache: write-through, no-write-allocate MEM-stage data cache with pipeline freeze
module mem_stage_cache
    import mips_mem_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      is_LB_SB,
    input  logic [31:0]               address,
    input  logic [31:0]               write_data,
    output byte_t [0:LINE_BYTES-1]    cache_data_out,
    output logic [1:0]                mem_block,
    output logic                      freeze,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
    mem_stage_cache_if.master         mif
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    mem_state_t            state_q, state_d;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [3:0]            be_q, be_d;
    logic [31:2]           lookup;
    logic                  rd_valid, hit, fill_we;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data, fill_data, out_word;
    logic [3:0]            fill_be;
    // while a transaction is outstanding the cache is probed with the held address
    assign lookup = (state_q == IDLE) ? address[31:2] : addr_q[31:2];
    assign hit    = rd_valid && (rd_tag == lookup[31:INDEX_BITS+2]);
    cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_index (lookup[INDEX_BITS+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_index (lookup[INDEX_BITS+1:2]),
        .wr_tag   (lookup[31:INDEX_BITS+2]),
        .wr_be    (fill_be),
        .wr_data  (fill_data)
    );
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        freeze     = 1'b0;
        out_word   = '0;
        fill_we    = 1'b0;
        fill_be    = 4'hF;
        fill_data  = mif.mem_rdata;
        if (rst_b) begin
            case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        freeze  = 1'b1;
                        state_d = WR_WAIT;
                        addr_d  = {address[31:2], 2'b00};
                        wdata_d = is_LB_SB ? {4{write_data[7:0]}} : write_data;
                        be_d    = is_LB_SB ? sb_be(address[1:0]) : 4'hF;
                    end else if (mem_read && hit) begin
                        out_word  = rd_data;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else if (mem_read) begin
                        freeze     = 1'b1;
                        state_d    = RD_WAIT;
                        addr_d     = {address[31:2], 2'b00};
                        miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                end
                RD_WAIT: begin
                    freeze   = ~mif.mem_ready;
                    out_word = mif.mem_ready ? mif.mem_rdata : '0;
                    fill_we  = mif.mem_ready;
                    state_d  = mif.mem_ready ? IDLE : RD_WAIT;
                end
                WR_WAIT: begin
                    freeze    = ~mif.mem_ready;
                    fill_we   = mif.mem_ready && hit;
                    fill_be   = be_q;
                    fill_data = wdata_q;
                    state_d   = mif.mem_ready ? IDLE : WR_WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_b && state_q == IDLE)
            assert (!(mem_read && mem_write))
            else $warning("mem_read and mem_write both set; serviced as a store");
    end
    assign cache_data_out = out_word;
    assign mem_block      = address[1:0];
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;
    assign mif.mem_req    = rst_b && (state_q != IDLE);
    assign mif.mem_we     = rst_b && (state_q == WR_WAIT);
    assign mif.mem_addr   = addr_q;
    assign mif.mem_wdata  = wdata_q;
    assign mif.mem_be     = be_q;
endmodule

// File: tb/tb_mem_stage_cache.sv
// tb_mem_stage_cache: randomized scoreboard bench with a word-level memory/cache reference model
module tb_mem_stage_cache;
    import mips_mem_pkg::*;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
    } txn_t;
    typedef struct {
        logic        is_load;
        logic        hit;
        logic [31:0] data;
        logic [1:0]  blk;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;
    logic clk = 1'b0, rst_b = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, is_LB_SB = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    byte_t [0:3] cache_data_out;
    logic [1:0]  mem_block;
    logic        freeze;
    logic [31:0] hit_count, miss_count;
    mem_stage_cache_if mif();
    mem_stage_cache #(.INDEX_BITS(4)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .address        (address),
        .write_data     (write_data),
        .cache_data_out (cache_data_out),
        .mem_block      (mem_block),
        .freeze         (freeze),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .mif            (mif)
    );
    always #5 clk = ~clk;
    int n_checks = 0, n_pass = 0;
    txn_t txq[$];
    exp_t sbq[$];
    logic [31:0] mem_m [logic [29:0]];
    bit          mvalid [16];
    logic [25:0] mtag [16];
    logic [31:0] m_hits = '0, m_misses = '0;
    logic [31:0] last_load = '0;
    bit          hold_ready = 1'b0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask
    function automatic logic [31:0] word_of(input logic [29:0] w);
        return mem_m.exists(w) ? mem_m[w] : ({w[15:0], ~w[15:0]} ^ 32'h5A3C_96E1);
    endfunction
    // Reference: main memory is a word map; the cache is just "which tag owns each index".
    // Write-through means any load, hit or miss, returns the current memory word.
    task automatic model_op(input bit wr, input bit lb, input logic [31:0] a, input logic [31:0] wd);
        logic [29:0] w;
        logic [3:0]  idx;
        logic [25:0] tg;
        byte_t [0:3] cur;
        logic [3:0]  be;
        w   = a[31:2];
        idx = a[5:2];
        tg  = a[31:6];
        cur = word_of(w);
        if (wr) begin
            be = lb ? 4'(1 << (3 - a[1:0])) : 4'hF;
            if (lb) cur[a[1:0]] = wd[7:0];
            else cur = wd;
            mem_m[w] = cur;
            txq.push_back('{we: 1'b1, addr: {w, 2'b00}, wdata: lb ? {4{wd[7:0]}} : wd, rdata: 32'h0, be: be});
            sbq.push_back('{is_load: 1'b0, hit: 1'b0, data: 32'h0, blk: a[1:0], hits: m_hits, misses: m_misses});
        end else if (mvalid[idx] && mtag[idx] == tg) begin
            // hit counter ticks at the end of the hit cycle, so it still shows the old value
            sbq.push_back('{is_load: 1'b1, hit: 1'b1, data: cur, blk: a[1:0], hits: m_hits, misses: m_misses});
            m_hits++;
        end else begin
            m_misses++;
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            txq.push_back('{we: 1'b0, addr: {w, 2'b00}, wdata: 32'h0, rdata: cur, be: 4'h0});
            sbq.push_back('{is_load: 1'b1, hit: 1'b0, data: cur, blk: a[1:0], hits: m_hits, misses: m_misses});
        end
    endtask
    // Monitor: an instruction retires at a negedge where it is presented and freeze is low
    int fz_cycles = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) fz_cycles = 0;
        else if (!(mem_read || mem_write)) begin
            chk("idle_freeze", {31'b0, freeze}, 32'h0);
            chk("idle_data_out", cache_data_out, 32'h0);
        end else if (freeze) fz_cycles++;
        else begin
            chk("completion_expected", {31'b0, sbq.size() > 0}, 32'h1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.is_load) begin
                    chk("load_data", cache_data_out, e.data);
                    chk("mem_block", {30'b0, mem_block}, {30'b0, e.blk});
                    last_load = cache_data_out;
                end
                if (e.hit) begin
                    chk("hit_no_stall", fz_cycles, 0);
                    chk("hit_no_req", {31'b0, mif.mem_req}, 32'h0);
                end else begin
                    chk("miss_stalled", {31'b0, fz_cycles > 0}, 32'h1);
                    chk("release_on_ready", {31'b0, mif.mem_ready}, 32'h1);
                end
                chk("hit_count", hit_count, e.hits);
                chk("miss_count", miss_count, e.misses);
            end
            fz_cycles = 0;
        end
    end
    // Memory responder: checks each request against the expected transaction, answers after a random delay
    initial begin
        txn_t cur;
        bit   busy;
        int   lat;
        busy = 1'b0;
        lat  = 0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mif.mem_ready = 1'b0;
            if (!rst_b) busy = 1'b0;
            else if (busy) begin
                chk("req_held", {31'b0, mif.mem_req}, 32'h1);
                chk("addr_stable", mif.mem_addr, cur.addr);
                if (lat > 0) lat--;
                else if (!hold_ready) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = cur.we ? $urandom : cur.rdata;
                    busy = 1'b0;
                end
            end else if (mif.mem_req) begin
                chk("req_expected", {31'b0, txq.size() > 0}, 32'h1);
                cur = (txq.size() > 0) ? txq.pop_front() : '{we: mif.mem_we, addr: mif.mem_addr, wdata: 32'h0, rdata: 32'h0, be: 4'h0};
                chk("mem_we", {31'b0, mif.mem_we}, {31'b0, cur.we});
                chk("mem_addr", mif.mem_addr, cur.addr);
                if (cur.we) begin
                    chk("mem_wdata", mif.mem_wdata, cur.wdata);
                    chk("mem_be", {28'b0, mif.mem_be}, {28'b0, cur.be});
                end
                busy = 1'b1;
                lat  = $urandom_range(0, 3);
            end else if ($urandom_range(0, 7) == 0) begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = $urandom;
            end
        end
    end
    task automatic issue(input bit rd, input bit wr, input bit lb, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_read   = rd;
        mem_write  = wr;
        is_LB_SB   = lb;
        address    = a;
        write_data = wd;
        model_op(wr, lb, a, wd);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!freeze) return;
        end
        chk("op_completes", {31'b0, ~freeze}, 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask
    task automatic idle();
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask
    initial begin
        @(negedge clk);
        chk("rst_freeze", {31'b0, freeze}, 32'h0);
        chk("rst_req", {31'b0, mif.mem_req}, 32'h0);
        @(negedge clk);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        chk("rst_mem_addr", mif.mem_addr, 32'h0);
        chk("rst_mem_be", {28'b0, mif.mem_be}, 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        mem_m[30'h40] = 32'hDEAD_BEEF;
        issue(1, 0, 0, 32'h100, 32'h0);
        idle();
        chk("t1_data", last_load, 32'hDEAD_BEEF);
        chk("t1_miss_count", miss_count, 32'h1);
        issue(1, 0, 0, 32'h100, 32'h0);
        idle();
        chk("t2_hit_count", hit_count, 32'h1);
        issue(0, 1, 1, 32'h102, 32'h0000_0055);
        issue(1, 0, 0, 32'h100, 32'h0);
        idle();
        chk("t3_data", last_load, 32'hDEAD_55EF);
        issue(0, 1, 0, 32'h200, 32'hCAFE_F00D);
        issue(1, 0, 0, 32'h200, 32'h0);
        idle();
        chk("t4_miss_count", miss_count, 32'h2);
        chk("t4_data", last_load, 32'hCAFE_F00D);
        issue(1, 0, 0, 32'h104, 32'h0);
        issue(1, 0, 0, 32'h104, 32'h0);
        // reset while a read is outstanding; memory is told never to answer it
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        address  = 32'h500;
        txq.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, rdata: 32'h0, be: 4'h0});
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("t5_rst_req", {31'b0, mif.mem_req}, 32'h0);
        chk("t5_rst_freeze", {31'b0, freeze}, 32'h0);
        chk("t5_rst_data_out", cache_data_out, 32'h0);
        @(posedge clk);
        #1;
        rst_b    = 1'b1;
        mem_read = 1'b0;
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        m_hits     = '0;
        m_misses   = '0;
        hold_ready = 1'b0;
        @(negedge clk);
        chk("t5_req_after", {31'b0, mif.mem_req}, 32'h0);
        chk("t5_miss_count", miss_count, 32'h0);
        issue(1, 0, 0, 32'h104, 32'h0);
        issue(1, 0, 0, 32'h100, 32'h0);
        issue(1, 1, 0, 32'h300, 32'h1234_5678);
        issue(1, 0, 0, 32'h300, 32'h0);
        idle();
        chk("t6_data", last_load, 32'h1234_5678);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int k;
            a = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) idle();
            issue(k == 0 || k >= 7, k < 7, 1'($urandom_range(0, 1)), a, $urandom);
        end
        repeat (3) idle();
        chk("sb_drained", sbq.size(), 0);
        chk("txq_drained", txq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
